save_state_sequencer: RTL and testbench

SAVE_STATE_SEQUENCER -- requirements
Module: save_state_sequencer

---
 rtl/ss_pkg.sv | 50 +++++
 rtl/ss_timeout_counter.sv | 36 +++
 rtl/save_state_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_save_state_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ss_pkg.sv
// Shared types and header layout for the save-state sequencer.
// Width codes select the element width: 0=8b, 1=16b, 2=32b, 3=64b.
package ss_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUERY,
        ST_HDR,
        ST_ACCESS,
        ST_MEM,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } ss_state_e;

    localparam int HDR_SIZE_LSB  = 0;
    localparam int HDR_SLOT_LSB  = 32;
    localparam int HDR_WIDTH_LSB = 40;

    localparam logic [1:0] WIDTH_8  = 2'd0;
    localparam logic [1:0] WIDTH_16 = 2'd1;
    localparam logic [1:0] WIDTH_32 = 2'd2;
    localparam logic [1:0] WIDTH_64 = 2'd3;

    function automatic logic [63:0] make_header(input logic [1:0] width,
                                                input logic [7:0] slot,
                                                input logic [31:0] size);
        logic [63:0] h;
        h = '0;
        h[HDR_SIZE_LSB  +: 32] = size;
        h[HDR_SLOT_LSB  +: 8]  = slot;
        h[HDR_WIDTH_LSB +: 2]  = width;
        return h;
    endfunction

    function automatic logic [63:0] zext_element(input logic [63:0] raw,
                                                 input logic [1:0] width);
        logic [63:0] r;
        r = raw;
        case (width)
            WIDTH_8:  r = {56'd0, raw[7:0]};
            WIDTH_16: r = {48'd0, raw[15:0]};
            WIDTH_32: r = {32'd0, raw[31:0]};
            WIDTH_64: r = raw;
            default:  r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ss_timeout_counter.sv
// Wait-cycle counter for slave accesses; expired_o asserts in the
// TIMEOUT-th consecutive waiting cycle after a load.
module ss_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    input  logic tick_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q >= CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (tick_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/save_state_sequencer.sv
// Walks every ssbus slot, streaming its state into (save) or out of (load)
// a linear memory image of one header word plus one word per element.
module save_state_sequencer
    import ss_pkg::*;
#(
    parameter int          NUM_SLOTS = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] MEM_BASE  = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_save,
    input  logic        start_load,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  ssbus_sel_o,
    output logic [31:0] ssbus_addr_o,
    output logic [63:0] ssbus_wdata_o,
    output logic        ssbus_read_o,
    output logic        ssbus_write_o,
    output logic        ssbus_query_o,
    input  logic        ssbus_ack_i,
    input  logic [63:0] ssbus_rdata_i,
    input  logic [31:0] ssbus_size_i,
    input  logic [1:0]  ssbus_width_i,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    ss_state_e   state_q, state_d;
    logic        save_q, save_d;
    logic        qphase_q, qphase_d;
    logic [7:0]  slot_q, slot_d;
    logic [31:0] size_q, size_d;
    logic [1:0]  width_q, width_d;
    logic [31:0] elem_q, elem_d;
    logic [28:0] widx_q, widx_d;
    logic [63:0] data_q, data_d;
    logic        mem_ack_q, mem_ack_d;

    logic mem_fire, ss_fire, last_elem, last_slot, hdr_ok;
    logic tmo_load, tmo_expired;

    assign mem_fire  = mem_req && mem_ack;
    assign ss_fire   = (ssbus_read_o || ssbus_write_o) && ssbus_ack_i;
    assign last_elem = (elem_q == size_q - 32'd1);
    assign last_slot = (slot_q == 8'(NUM_SLOTS - 1));
    assign hdr_ok    = (mem_rdata[HDR_SLOT_LSB +: 8] == slot_q) &&
                       (mem_rdata[HDR_SIZE_LSB +: 32] == size_q);
    assign tmo_load  = (state_d == ST_ACCESS) && (state_q != ST_ACCESS);

    ss_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (tmo_load),
        .tick_i    (state_q == ST_ACCESS),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_save || start_load) state_d = ST_QUERY;
            ST_QUERY:  if (qphase_q) state_d = (ssbus_size_i == 32'd0) ? ST_NEXT : ST_HDR;
            ST_HDR: begin
                if (mem_fire) begin
                    if (save_q)       state_d = ST_ACCESS;
                    else if (!hdr_ok) state_d = ST_ERROR;
                    else              state_d = ST_MEM;
                end
            end
            ST_ACCESS: begin
                if (ss_fire)          state_d = (save_q || !last_elem) ? ST_MEM : ST_NEXT;
                else if (tmo_expired) state_d = ST_ERROR;
            end
            ST_MEM:    if (mem_fire) state_d = (save_q && last_elem) ? ST_NEXT : ST_ACCESS;
            ST_NEXT:   state_d = last_slot ? ST_DONE : ST_QUERY;
            ST_DONE:   state_d = ST_IDLE;
            ST_ERROR:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from registered state only, so reset clears them at once.
    always_comb begin
        busy          = (state_q != ST_IDLE);
        done          = (state_q == ST_DONE);
        error         = (state_q == ST_ERROR);
        ssbus_query_o = (state_q == ST_QUERY);
        ssbus_read_o  = (state_q == ST_ACCESS) && save_q;
        ssbus_write_o = (state_q == ST_ACCESS) && !save_q;
        ssbus_sel_o   = (state_q inside {ST_QUERY, ST_HDR, ST_ACCESS, ST_MEM}) ? slot_q : 8'd0;
        ssbus_addr_o  = (state_q == ST_ACCESS) ? elem_q : 32'd0;
        ssbus_wdata_o = ssbus_write_o ? data_q : 64'd0;
        mem_req       = (state_q inside {ST_HDR, ST_MEM}) && !mem_ack_q;
        mem_we        = mem_req && save_q;
        mem_addr      = mem_req ? (MEM_BASE + {widx_q, 3'b000}) : 32'd0;
        mem_wdata     = 64'd0;
        if (mem_we) begin
            mem_wdata = (state_q == ST_HDR) ? make_header(width_q, slot_q, size_q) : data_q;
        end
    end

    always_comb begin
        save_d    = save_q;
        qphase_d  = qphase_q;
        slot_d    = slot_q;
        size_d    = size_q;
        width_d   = width_q;
        elem_d    = elem_q;
        widx_d    = widx_q;
        data_d    = data_q;
        mem_ack_d = mem_fire;
        if (mem_fire) begin
            widx_d = widx_q + 29'd1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start_save || start_load) begin
                    save_d   = start_save;
                    slot_d   = 8'd0;
                    widx_d   = 29'd0;
                    qphase_d = 1'b0;
                end
            end
            ST_QUERY: begin
                qphase_d = ~qphase_q;
                if (qphase_q) begin
                    size_d  = ssbus_size_i;
                    width_d = ssbus_width_i;
                    elem_d  = 32'd0;
                end
            end
            ST_ACCESS: begin
                if (ss_fire && save_q)                data_d = zext_element(ssbus_rdata_i, width_q);
                if (ss_fire && !save_q && !last_elem) elem_d = elem_q + 32'd1;
            end
            ST_MEM: begin
                if (mem_fire && !save_q)              data_d = mem_rdata;
                if (mem_fire && save_q && !last_elem) elem_d = elem_q + 32'd1;
            end
            ST_NEXT: begin
                qphase_d = 1'b0;
                if (!last_slot) slot_d = slot_q + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            save_q    <= 1'b0;
            qphase_q  <= 1'b0;
            slot_q    <= 8'd0;
            size_q    <= 32'd0;
            width_q   <= 2'd0;
            elem_q    <= 32'd0;
            widx_q    <= 29'd0;
            data_q    <= 64'd0;
            mem_ack_q <= 1'b0;
        end else begin
            save_q    <= save_d;
            qphase_q  <= qphase_d;
            slot_q    <= slot_d;
            size_q    <= size_d;
            width_q   <= width_d;
            elem_q    <= elem_d;
            widx_q    <= widx_d;
            data_q    <= data_d;
            mem_ack_q <= mem_ack_d;
        end
    end

endmodule

// File: tb/tb_save_state_sequencer.sv
// Bench for save_state_sequencer: randomized slaves and memory compared
// against an image/write-list model built from the slot configuration.
module tb_save_state_sequencer;

    localparam int NS   = 16;
    localparam int TMO  = 8;
    localparam int MEMW = 128;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_save = 1'b0, start_load = 1'b0;
    logic        busy, done, error;
    logic [7:0]  ssbus_sel_o;
    logic [31:0] ssbus_addr_o;
    logic [63:0] ssbus_wdata_o;
    logic        ssbus_read_o, ssbus_write_o, ssbus_query_o;
    logic        ssbus_ack_i = 1'b0;
    logic [63:0] ssbus_rdata_i = '0;
    logic [31:0] ssbus_size_i = '0;
    logic [1:0]  ssbus_width_i = '0;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we, mem_req;
    logic        mem_ack = 1'b0;
    logic [63:0] mem_rdata = '0;

    always #5 clk = ~clk;

    save_state_sequencer #(.NUM_SLOTS(NS), .TIMEOUT(TMO), .MEM_BASE(32'h0)) dut (
        .clk(clk), .reset_n(reset_n), .start_save(start_save), .start_load(start_load),
        .busy(busy), .done(done), .error(error),
        .ssbus_sel_o(ssbus_sel_o), .ssbus_addr_o(ssbus_addr_o), .ssbus_wdata_o(ssbus_wdata_o),
        .ssbus_read_o(ssbus_read_o), .ssbus_write_o(ssbus_write_o), .ssbus_query_o(ssbus_query_o),
        .ssbus_ack_i(ssbus_ack_i), .ssbus_rdata_i(ssbus_rdata_i),
        .ssbus_size_i(ssbus_size_i), .ssbus_width_i(ssbus_width_i),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct { int slot; int addr; logic [63:0] data; } wr_t;

    int          slot_size [NS];
    logic [1:0]  slot_width [NS];
    logic [63:0] slot_val [NS][4];
    logic [63:0] mem [MEMW];
    logic [63:0] img [$];
    wr_t         exp_wr [$];
    wr_t         wr_log [$];
    int dead_slot = -1, ss_lat_max = 2, mem_lat_max = 2;
    int mem_writes = 0, first_we = -1, misaligned = 0, req_viol = 0;
    int n_checks = 0, n_fail = 0;
    int g_done, g_err, g_cyc, t_rd, t_err, t_end;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ssbus slave: answers query with slot config, read/write after random latency.
    initial begin : ss_slave
        int wait_n = 0;
        forever begin
            @(negedge clk);
            if (ssbus_ack_i || !reset_n) begin
                ssbus_ack_i = 1'b0;
                wait_n = $urandom_range(0, ss_lat_max);
            end else if ((ssbus_read_o || ssbus_write_o) && int'(ssbus_sel_o) != dead_slot) begin
                if (wait_n > 0) wait_n--;
                else begin
                    ssbus_ack_i = 1'b1;
                    if (ssbus_read_o) ssbus_rdata_i = slot_val[ssbus_sel_o[3:0]][ssbus_addr_o[1:0]];
                    else wr_log.push_back('{int'(ssbus_sel_o), int'(ssbus_addr_o), ssbus_wdata_o});
                end
            end
            ssbus_size_i  = ssbus_query_o ? 32'(slot_size[ssbus_sel_o[3:0]]) : $urandom;
            ssbus_width_i = ssbus_query_o ? slot_width[ssbus_sel_o[3:0]] : 2'($urandom);
        end
    end

    initial begin : mem_slave
        int wait_n = 0;
        forever begin
            @(negedge clk);
            if (mem_ack || !reset_n) begin
                if (mem_ack && mem_req) req_viol++;
                mem_ack = 1'b0;
                wait_n = $urandom_range(0, mem_lat_max);
            end else if (mem_req) begin
                if (first_we < 0) first_we = int'(mem_we);
                if (mem_addr[2:0] != 3'd0) misaligned++;
                if (wait_n > 0) wait_n--;
                else begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[9:3]] = mem_wdata;
                        mem_writes++;
                    end else begin
                        mem_rdata = mem[mem_addr[9:3]];
                    end
                end
            end
        end
    end

    function automatic logic [63:0] zext_w(input logic [63:0] v, input logic [1:0] w);
        int bits = 8 << w;
        if (bits >= 64) return v;
        return v & ((64'd1 << bits) - 64'd1);
    endfunction

    // Expected memory image and load-phase slave writes, derived from the slot config.
    task automatic build_model();
        img.delete();
        exp_wr.delete();
        for (int s = 0; s < NS; s++) begin
            if (slot_size[s] != 0) begin
                img.push_back((64'(slot_width[s]) << 40) | (64'(s) << 32) | 64'(slot_size[s]));
                for (int e = 0; e < slot_size[s]; e++) begin
                    img.push_back(zext_w(slot_val[s][e], slot_width[s]));
                    exp_wr.push_back('{s, e, zext_w(slot_val[s][e], slot_width[s])});
                end
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < MEMW; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        mem_writes = 0;
    endtask

    task automatic random_slots();
        for (int s = 0; s < NS; s++) begin
            slot_size[s]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            slot_width[s] = 2'($urandom_range(0, 3));
            for (int e = 0; e < 4; e++) slot_val[s][e] = {$urandom, $urandom};
        end
    endtask

    task automatic directed_slots();
        for (int s = 0; s < NS; s++) begin
            slot_size[s]  = 0;
            slot_width[s] = 2'd1;
            for (int e = 0; e < 4; e++) slot_val[s][e] = {$urandom, $urandom};
        end
        slot_size[0] = 4;
        slot_size[3] = 2;
    endtask

    task automatic run_op(input logic do_save, input logic do_load);
        @(negedge clk);
        start_save = do_save;
        start_load = do_load;
        first_we = -1;
        @(negedge clk);
        start_save = 1'b0;
        start_load = 1'b0;
        check_eq("busy_after_start", busy, 1'b1);
        g_done = 0; g_err = 0; g_cyc = 0; t_rd = -1; t_err = -1;
        while (busy && g_cyc < 5000) begin
            if (done) g_done++;
            if (error) begin g_err++; t_err = g_cyc; end
            if (ssbus_read_o && int'(ssbus_sel_o) == dead_slot && t_rd < 0) t_rd = g_cyc;
            @(negedge clk);
            g_cyc++;
        end
        t_end = g_cyc;
        check_eq("op_bounded", busy, 1'b0);
    endtask

    task automatic check_image(input string tag);
        build_model();
        check_eq({tag, "_nwrites"}, 64'(mem_writes), 64'(img.size()));
        for (int i = 0; i < img.size(); i++)
            check_eq($sformatf("%s_word%0d", tag, i), mem[i], img[i]);
    endtask

    task automatic check_writes(input string tag);
        build_model();
        check_eq({tag, "_nwr"}, 64'(wr_log.size()), 64'(exp_wr.size()));
        for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
            check_eq($sformatf("%s_wr%0d_slot", tag, i), 64'(wr_log[i].slot), 64'(exp_wr[i].slot));
            check_eq($sformatf("%s_wr%0d_addr", tag, i), 64'(wr_log[i].addr), 64'(exp_wr[i].addr));
            check_eq($sformatf("%s_wr%0d_data", tag, i), wr_log[i].data, exp_wr[i].data);
        end
    endtask

    initial begin : main
        int n3, n0, idle_pulses, wait_c;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", {busy, done, error, mem_req, mem_we, ssbus_read_o, ssbus_write_o, ssbus_query_o}, 8'd0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed save: slot 0 size 4, slot 3 size 2, width 16b.
        directed_slots();
        clear_mem();
        run_op(1'b1, 1'b0);
        check_eq("save_done", 64'(g_done), 1);
        check_eq("save_err", 64'(g_err), 0);
        check_eq("save_word_index", 64'(mem_writes), 8);
        check_eq("save_hdr0", mem[0], 64'h0000_0100_0000_0004);
        check_eq("save_hdr3_at_0x28", mem[5], 64'h0000_0103_0000_0002);
        check_eq("save_elem0_16b", mem[1], {48'd0, slot_val[0][0][15:0]});
        check_image("save");

        // Load that image back.
        wr_log.delete();
        run_op(1'b0, 1'b1);
        check_eq("load_done", 64'(g_done), 1);
        check_eq("load_err", 64'(g_err), 0);
        check_writes("load");

        // Corrupted header size for slot 3.
        mem[5] = 64'h0000_0103_0000_0003;
        wr_log.delete();
        run_op(1'b0, 1'b1);
        check_eq("badhdr_err", 64'(g_err), 1);
        check_eq("badhdr_done", 64'(g_done), 0);
        n3 = 0; n0 = 0;
        foreach (wr_log[i]) begin
            if (wr_log[i].slot == 3) n3++;
            if (wr_log[i].slot == 0) n0++;
        end
        check_eq("badhdr_slot3_writes", 64'(n3), 0);
        check_eq("badhdr_slot0_writes", 64'(n0), 4);

        // Slave 3 never responds.
        dead_slot = 3;
        clear_mem();
        run_op(1'b1, 1'b0);
        check_eq("tmo_err", 64'(g_err), 1);
        check_eq("tmo_done", 64'(g_done), 0);
        check_eq("tmo_latency", 64'(t_err - t_rd), 8);
        check_eq("tmo_busy_drop", 64'(t_end - t_err), 1);
        dead_slot = -1;

        // Both starts together: save wins.
        clear_mem();
        run_op(1'b1, 1'b1);
        check_eq("both_first_we", 64'(first_we), 1);
        check_eq("both_done", 64'(g_done), 1);
        check_image("both");

        // Reset during slot 0 ACCESS.
        @(negedge clk);
        start_save = 1'b1;
        @(negedge clk);
        start_save = 1'b0;
        wait_c = 0;
        while (!ssbus_read_o && wait_c < 200) begin
            @(negedge clk);
            wait_c++;
        end
        check_eq("rst_mid_reached_access", {ssbus_read_o, ssbus_sel_o}, {1'b1, 8'd0});
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_mid_ctrl", {busy, done, error, mem_req, mem_we, ssbus_read_o, ssbus_write_o, ssbus_query_o}, 8'd0);
        check_eq("rst_mid_mem", {mem_addr, ssbus_addr_o}, 0);
        check_eq("rst_mid_sel", {ssbus_sel_o, ssbus_wdata_o[31:0]}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        idle_pulses = 0;
        repeat (10) begin
            @(negedge clk);
            idle_pulses += int'(busy) + int'(done) + int'(error);
        end
        check_eq("rst_mid_idle", 64'(idle_pulses), 0);

        // Randomized save/load round trips.
        for (int it = 0; it < 6; it++) begin
            random_slots();
            ss_lat_max  = $urandom_range(0, 3);
            mem_lat_max = $urandom_range(0, 3);
            clear_mem();
            run_op(1'b1, 1'($urandom_range(0, 1)));
            check_eq($sformatf("rnd%0d_save_done", it), 64'(g_done), 1);
            check_image($sformatf("rnd%0d_save", it));
            wr_log.delete();
            run_op(1'b0, 1'b1);
            check_eq($sformatf("rnd%0d_load_done", it), 64'(g_done), 1);
            check_eq($sformatf("rnd%0d_load_err", it), 64'(g_err), 0);
            check_writes($sformatf("rnd%0d_load", it));
        end

        check_eq("mem_addr_aligned", 64'(misaligned), 0);
        check_eq("mem_req_drops_after_ack", 64'(req_viol), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
